// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, register ids, status codes, word width.
// Also holds the control FSM state type and an exception helper.
package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } ctrl_state_t;

  function automatic logic exc(input logic [2:0] stat);
    return stat != S_AOK;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms and RUN-state pipeline control equations.
// In: D/E icodes, decode sources, E_dstM, e_Cnd, m_stat/W_stat. Out: stalls, bubbles, set_cc.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       set_cc
);

  logic load_use;
  logic ret_hz;
  logic mispred;

  assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ)
                  && E_dstM != RNONE
                  && (E_dstM == d_srcA || E_dstM == d_srcB);

  assign ret_hz = D_icode == I_RET || E_icode == I_RET
               || M_icode == I_RET;

  assign mispred = E_icode == I_JXX && !e_Cnd;

  assign F_stall  = load_use | ret_hz;
  assign D_stall  = load_use;
  // a stalled D must keep its instruction, so ret never bubbles it then
  assign D_bubble = mispred | (ret_hz & ~load_use);
  assign E_bubble = mispred | load_use;
  assign M_bubble = exc(m_stat) | exc(W_stat);
  assign W_stall  = exc(W_stat);
  assign set_cc   = E_icode == I_OPQ && !exc(m_stat) && !exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch-PC sequencer, pipeline control FSM and saturating stall counter.
// In: stage icodes/values/status. Out: f_pc, stalls/bubbles, set_cc, halted, stat_out, stall_cnt.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       f_icode,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic             M_Cnd,
  input  logic [63:0]      M_valA,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  input  logic [2:0]       W_stat,
  output logic [63:0]      f_pc,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       stat_out,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;

  logic [63:0] pred_pc;
  logic [63:0] pred_nxt;

  logic hz_f_stall;
  logic hz_d_stall;
  logic hz_d_bubble;
  logic hz_e_bubble;
  logic hz_m_bubble;
  logic hz_w_stall;
  logic hz_set_cc;

  hazard_detect u_hz (
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (hz_f_stall),
    .D_stall  (hz_d_stall),
    .D_bubble (hz_d_bubble),
    .E_bubble (hz_e_bubble),
    .M_bubble (hz_m_bubble),
    .W_stall  (hz_w_stall),
    .set_cc   (hz_set_cc)
  );

  always_comb begin
    f_pc = pred_pc;
    if (M_icode == I_JXX && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end
  end

  assign pred_nxt = (f_icode == I_JXX || f_icode == I_CALL)
                  ? f_valC : f_valP;

  always_comb begin
    state_nxt = state;
    halted    = 1'b0;
    F_stall   = hz_f_stall;
    D_stall   = hz_d_stall;
    D_bubble  = hz_d_bubble;
    E_bubble  = hz_e_bubble;
    M_bubble  = hz_m_bubble;
    W_stall   = hz_w_stall;
    set_cc    = hz_set_cc;
    unique case (state)
      ST_RUN: begin
        if (exc(W_stat)) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        halted   = 1'b1;
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pred_pc   <= RESET_PC;
      stat_out  <= S_AOK;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && exc(W_stat)) stat_out <= W_stat;
      if (!F_stall) pred_pc <= pred_nxt;
      if (F_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Counter width is shrunk to 3 bits so saturation is reachable.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    f_icode;
  logic [63:0]   f_valC;
  logic [63:0]   f_valP;
  logic [3:0]    D_icode;
  logic [3:0]    d_srcA;
  logic [3:0]    d_srcB;
  logic [3:0]    E_icode;
  logic [3:0]    E_dstM;
  logic          e_Cnd;
  logic [3:0]    M_icode;
  logic          M_Cnd;
  logic [63:0]   M_valA;
  logic [2:0]    m_stat;
  logic [3:0]    W_icode;
  logic [63:0]   W_valM;
  logic [2:0]    W_stat;
  logic [63:0]   f_pc;
  logic          F_stall;
  logic          D_stall;
  logic          D_bubble;
  logic          E_bubble;
  logic          M_bubble;
  logic          W_stall;
  logic          set_cc;
  logic          halted;
  logic [2:0]    stat_out;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .m_stat(m_stat), .W_icode(W_icode), .W_valM(W_valM),
    .W_stat(W_stat), .f_pc(f_pc), .F_stall(F_stall),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
    .halted(halted), .stat_out(stat_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic [6:0] exp);
    chk(tag, {F_stall, D_stall, D_bubble, E_bubble,
              M_bubble, W_stall, set_cc}, {57'd0, exp});
  endtask

  task automatic idle();
    f_icode = I_NOP; f_valC = 64'h0; f_valP = 64'h0A;
    D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = I_NOP; E_dstM = RNONE; e_Cnd = 1'b1;
    M_icode = I_NOP; M_Cnd = 1'b1; M_valA = 64'h0;
    m_stat = S_AOK; W_icode = I_NOP; W_valM = 64'h0;
    W_stat = S_AOK;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    // order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
    chk("rst_fpc", f_pc, 64'h0);
    ctl("rst_ctl", 7'b0000000);
    chk("rst_stat", stat_out, S_AOK);
    chk("rst_halt", halted, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    step();
    chk("idle_fpc", f_pc, 64'h0A);

    // load-use through d_srcA
    E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    f_valP = 64'h20;
    #1;
    ctl("lu_ctl", 7'b1101000);
    step();
    chk("lu_hold", f_pc, 64'h0A);
    chk("lu_cnt", stall_cnt, 1);
    E_icode = I_NOP; E_dstM = RNONE; d_srcA = RNONE;
    #1;
    ctl("lu_clr", 7'b0000000);
    step();
    chk("lu_adv", f_pc, 64'h20);

    // dstM of RNONE never counts as a load-use match
    E_icode = I_POPQ; d_srcA = RNONE; d_srcB = RNONE;
    #1;
    ctl("lu_rnone", 7'b0000000);
    E_icode = I_NOP;

    // jXX as next prediction uses valC
    f_icode = I_JXX; f_valC = 64'h33;
    step();
    chk("pred_jxx", f_pc, 64'h33);
    f_icode = I_CALL; f_valC = 64'h44;
    step();
    chk("pred_call", f_pc, 64'h44);
    f_icode = I_NOP; f_valP = 64'h20;
    step();
    chk("pred_valp", f_pc, 64'h20);

    // mispredict
    E_icode = I_JXX; e_Cnd = 1'b0;
    #1;
    ctl("mp_ctl", 7'b0011000);
    step();
    E_icode = I_NOP; e_Cnd = 1'b1;
    M_icode = I_JXX; M_Cnd = 1'b0; M_valA = 64'h40;
    #1;
    chk("mp_fpc", f_pc, 64'h40);
    M_Cnd = 1'b1;
    #1;
    chk("mp_taken", f_pc, 64'h20);
    M_icode = I_NOP;

    // set_cc gated by exceptions
    E_icode = I_OPQ;
    #1;
    ctl("cc_on", 7'b0000001);
    m_stat = S_ADR;
    #1;
    ctl("cc_mexc", 7'b0000100);
    m_stat = S_AOK; E_icode = I_NOP;

    // ret walking D->E->M
    D_icode = I_RET;
    #1;
    ctl("ret_d", 7'b1010000);
    step();
    D_icode = I_NOP; E_icode = I_RET;
    #1;
    ctl("ret_e", 7'b1010000);
    step();
    E_icode = I_NOP; M_icode = I_RET;
    #1;
    ctl("ret_m", 7'b1010000);
    step();
    M_icode = I_NOP; W_icode = I_RET; W_valM = 64'h100;
    #1;
    chk("ret_fpc", f_pc, 64'h100);
    chk("ret_fst", F_stall, 1'b0);
    chk("ret_cnt", stall_cnt, 4);
    W_icode = I_NOP;

    // mispredict recovery outranks ret target
    M_icode = I_JXX; M_Cnd = 1'b0; M_valA = 64'h40;
    W_icode = I_RET;
    #1;
    chk("prio_fpc", f_pc, 64'h40);
    M_icode = I_NOP; M_Cnd = 1'b1; W_icode = I_NOP;

    // load-use and ret together: stall D, no bubble
    E_icode = I_POPQ; E_dstM = 4'd4; d_srcB = 4'd4; D_icode = I_RET;
    #1;
    ctl("lu_ret", 7'b1101000);

    // saturate the 3-bit counter: 4 + 5 edges -> 7
    for (int i = 0; i < 5; i++) step();
    chk("cnt_sat", stall_cnt, 7);
    step();
    chk("cnt_nowrap", stall_cnt, 7);
    idle();

    // halt
    f_valP = 64'h50;
    W_stat = S_HLT;
    #1;
    ctl("hlt_pre", 7'b0000110);
    chk("hlt_pre_h", halted, 1'b0);
    chk("hlt_pre_s", stat_out, S_AOK);
    step();
    chk("hlt_h", halted, 1'b1);
    chk("hlt_s", stat_out, S_HLT);
    W_stat = S_ADR; E_icode = I_JXX; e_Cnd = 1'b0;
    f_valP = 64'h77;
    #1;
    ctl("hlt_ctl", 7'b1100010);
    step();
    chk("hlt_fpc", f_pc, 64'h50);
    chk("hlt_s2", stat_out, S_HLT);
    E_icode = I_OPQ; W_stat = S_AOK;
    step();
    chk("hlt_h2", halted, 1'b1);
    ctl("hlt_cc", 7'b1100010);

    // reset from halted
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rr_h", halted, 1'b0);
    chk("rr_s", stat_out, S_AOK);
    chk("rr_cnt", stall_cnt, 0);
    chk("rr_fpc", f_pc, 64'h0);
    ctl("rr_ctl", 7'b0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control and fetch-PC sequencer for the pipelined Y86-64 core.
- Owns the predicted-PC register and selects the fetch PC each cycle (predicted, mispredict recovery, or ret target).
- Generates stall/bubble/set_cc controls for the F/D/E/M/W pipeline registers.
- Tracks processor status through a sticky run/halt FSM and keeps a saturating stall-cycle counter.

Parameters:
- RESET_PC, 64'h0, fetch address after reset.
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_icode  in  4  icode of instruction being fetched.
- f_valC  in  64  fetched constant.
- f_valP  in  64  fall-through PC of fetched instruction.
- D_icode  in  4  icode in D register.
- d_srcA  in  4  decode source A register id (4'hF = none).
- d_srcB  in  4  decode source B register id.
- E_icode  in  4  icode in E register.
- E_dstM  in  4  memory destination register id in E.
- e_Cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode in M register.
- M_Cnd  in  1  latched condition in M.
- M_valA  in  64  fall-through PC carried by jXX in M.
- m_stat  in  3  status produced in memory stage.
- W_icode  in  4  icode in W register.
- W_valM  in  64  value read by memory (ret target).
- W_stat  in  3  status in W register.
- f_pc  out  64  PC to fetch this cycle.
- F_stall  out  1  hold F register.
- D_stall  out  1  hold D register.
- D_bubble  out  1  inject nop into D.
- E_bubble  out  1  inject nop into E.
- M_bubble  out  1  inject nop into M.
- W_stall  out  1  hold W register.
- set_cc  out  1  permit CC update in execute.
- halted  out  1  processor stopped.
- stat_out  out  3  architectural status.
- stall_cnt  out  CNT_W  cycles with F_stall asserted.

Behaviour:
- Reset (synchronous): F_predPC=RESET_PC; state=RUN; stat_out=AOK(1); stall_cnt=0; halted=0.
- Constants:
  - icodes: HALT=0, OPQ=6, JXX=7, CALL=8, RET=9, MRMOVQ=5, POPQ=B.
  - RNONE=F.
  - stat: AOK=1, HLT=2, ADR=3, INS=4; "exception" means stat != AOK.
- f_pc is combinational, evaluated in priority order:
  1. M_icode==JXX and !M_Cnd: M_valA.
  2. Else W_icode==RET: W_valM.
  3. Else F_predPC.
- F_predPC next value: f_valC if f_icode is JXX or CALL, else f_valP. Loaded each edge unless F_stall is high; loads 0 latency.
- Hazard terms:
  - load_use = E_icode in {MRMOVQ,POPQ} and E_dstM!=RNONE and E_dstM in {d_srcA,d_srcB}.
  - ret_hz = RET in {D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX and !e_Cnd.
- Controls in RUN:
  - F_stall = load_use | ret_hz.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_hz & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - set_cc = E_icode==OPQ & !exc(m_stat) & !exc(W_stat).
- Simultaneous load_use and ret_hz: D stalls, it is not bubbled.
- D_stall and D_bubble are never both 1.
- FSM (2 states):
  - RUN to HALTED on the edge where exc(W_stat); stat_out latches W_stat on that same edge.
  - HALTED is sticky until reset.
  - In HALTED: halted=1; F_stall=D_stall=W_stall=1; all bubbles=0; set_cc=0; F_predPC frozen.
- stall_cnt increments on each edge with F_stall=1. It saturates at all-ones and does not wrap.
- Reset mid-operation: reset overrides all state updates in the same edge. The outputs in the following cycle reflect the reset state only.

Decomposition:
- Shared package (y86_pkg): icode constants, RNONE, stat codes, and the 64-bit word width. The fetch, decode and execute modules reuse these.
- One natural sub-module, hazard_detect: the purely combinational load_use/ret_hz/mispred terms plus the control equations. pipe_ctrl keeps the predPC register, FSM, f_pc mux and counter.

Test Plan:
1. Reset, then idle with nop icodes and f_valP=64'h0A: f_pc=RESET_PC=0 in cycle 0 and 64'h0A in cycle 1. All stalls/bubbles are 0 and stat_out=1.
2. Load-use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. F_predPC holds and stall_cnt increments by 1.
3. Mispredict: E_icode=JXX, e_Cnd=0 → D_bubble=1, E_bubble=1. Next cycle, with M_icode=JXX, M_Cnd=0, M_valA=64'h40: f_pc=64'h40.
4. Ret sequence: RET advancing D→E→M gives 3 cycles of F_stall=1 and D_bubble=1. Then with W_icode=RET and W_valM=64'h100: f_pc=64'h100 and F_stall=0.
5. Load-use plus ret together: E_icode=POPQ, E_dstM=d_srcB=4, D_icode=RET → D_stall=1 and D_bubble=0.
6. Halt: W_stat=HLT(2) → M_bubble=1 and W_stall=1. On the next edge halted=1 and stat_out=2, and this persists through arbitrary inputs until reset is asserted.
